// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM access arbiter.
//   RAM_ADDR_W / RAM_DATA_W : default geometry of the lab 32x8 RAM
//   RAM_DEPTH               : number of words swept by a clear
//   state_e                 : sequencer states
package ram_ctrl_pkg;

    localparam int unsigned RAM_ADDR_W = 5;
    localparam int unsigned RAM_DATA_W = 8;
    localparam int unsigned RAM_DEPTH  = 32;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StIssue,
        StCapture
    } state_e;

endpackage

// File: rtl/scan_tick_gen.sv
// Scan tick divider: counts 0..SCAN_DIV-1 while enabled and emits a one-cycle
// tick on the terminal count. Held at 0 while disabled.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   en_i   : count enable
//   tick_o : one-cycle pulse every SCAN_DIV enabled cycles
module scan_tick_gen #(
    parameter int unsigned SCAN_DIV = 50000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(SCAN_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Sequencer/arbiter sharing a single-port synchronous RAM between a user port,
// a periodic display scanner and a zero-fill clear engine.
//   clk50M, reset              : clock, asynchronous active-high reset
//   clr_req / busy             : clear request, clear in progress
//   a_req/a_we/a_addr/a_wdata  : user request (held until a_ack)
//   a_ack / a_rdata            : user completion pulse, read data
//   scan_en                    : enables scan ticks
//   scan_addr/scan_data/scan_valid : last scanned word and its update pulse
//   ram_addr/ram_wdata/ram_we/ram_q : registered RAM interface
module ram_access_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = RAM_ADDR_W,
    parameter int unsigned DATA_W   = RAM_DATA_W,
    parameter int unsigned SCAN_DIV = 50000000
) (
    input  logic              clk50M,
    input  logic              reset,
    input  logic              clr_req,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              scan_en,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_valid,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    logic scan_tick;

    scan_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan_tick_gen (
        .clk_i (clk50M),
        .rst_i (reset),
        .en_i  (scan_en),
        .tick_o(scan_tick)
    );

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic              a_ack_q, a_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
    logic [DATA_W-1:0] scan_data_q, scan_data_d;
    logic              scan_valid_q, scan_valid_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] scan_ptr_q, scan_ptr_d;
    logic              scan_pend_q, scan_pend_d;
    logic              last_scan_q, last_scan_d;  // last grant went to the scanner
    logic              op_scan_q, op_scan_d;      // access in flight belongs to the scanner
    logic              op_wr_q, op_wr_d;          // access in flight is a user write

    always_comb begin
        state_d      = state_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_we_d     = ram_we_q;
        a_ack_d      = 1'b0;
        a_rdata_d    = a_rdata_q;
        scan_addr_d  = scan_addr_q;
        scan_data_d  = scan_data_q;
        scan_valid_d = 1'b0;
        busy_d       = busy_q;
        scan_ptr_d   = scan_ptr_q;
        scan_pend_d  = scan_pend_q;
        last_scan_d  = last_scan_q;
        op_scan_d    = op_scan_q;
        op_wr_d      = op_wr_q;

        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d     = StClear;
                    busy_d      = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_wdata_d = '0;
                    ram_addr_d  = '0;
                end else if (a_req && (!scan_pend_q || last_scan_q)) begin
                    // User wins when alone or when the scanner had the last turn.
                    state_d     = StIssue;
                    ram_addr_d  = a_addr;
                    ram_wdata_d = a_wdata;
                    ram_we_d    = a_we;
                    op_scan_d   = 1'b0;
                    op_wr_d     = a_we;
                    last_scan_d = 1'b0;
                end else if (scan_pend_q) begin
                    state_d     = StIssue;
                    ram_addr_d  = scan_ptr_q;
                    ram_wdata_d = '0;
                    ram_we_d    = 1'b0;
                    op_scan_d   = 1'b1;
                    op_wr_d     = 1'b0;
                    last_scan_d = 1'b1;
                    scan_pend_d = 1'b0;
                end
            end
            StClear: begin
                if (ram_addr_q == '1) begin
                    state_d  = StIdle;
                    busy_d   = 1'b0;
                    ram_we_d = 1'b0;
                end else begin
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                end
            end
            StIssue: begin
                ram_we_d = 1'b0;
                state_d  = StCapture;
            end
            StCapture: begin
                state_d = StIdle;
                if (op_scan_q) begin
                    scan_data_d  = ram_q;
                    scan_addr_d  = scan_ptr_q;
                    scan_ptr_d   = scan_ptr_q + ADDR_W'(1);
                    scan_valid_d = 1'b1;
                end else begin
                    a_ack_d = 1'b1;
                    if (!op_wr_q) begin
                        a_rdata_d = ram_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A tick arriving while one is already pending is dropped.
        if (scan_tick && !scan_pend_q) begin
            scan_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_we_q     <= 1'b0;
            a_ack_q      <= 1'b0;
            a_rdata_q    <= '0;
            scan_addr_q  <= '0;
            scan_data_q  <= '0;
            scan_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            scan_ptr_q   <= '0;
            scan_pend_q  <= 1'b0;
            last_scan_q  <= 1'b1;
            op_scan_q    <= 1'b0;
            op_wr_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_we_q     <= ram_we_d;
            a_ack_q      <= a_ack_d;
            a_rdata_q    <= a_rdata_d;
            scan_addr_q  <= scan_addr_d;
            scan_data_q  <= scan_data_d;
            scan_valid_q <= scan_valid_d;
            busy_q       <= busy_d;
            scan_ptr_q   <= scan_ptr_d;
            scan_pend_q  <= scan_pend_d;
            last_scan_q  <= last_scan_d;
            op_scan_q    <= op_scan_d;
            op_wr_q      <= op_wr_d;
        end
    end

    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_we     = ram_we_q;
    assign a_ack      = a_ack_q;
    assign a_rdata    = a_rdata_q;
    assign scan_addr  = scan_addr_q;
    assign scan_data  = scan_data_q;
    assign scan_valid = scan_valid_q;
    assign busy       = busy_q;

endmodule

// File: doc/ram_access_arbiter.md
# ram_access_arbiter

Sequencer and arbiter for the lab's 32x8 single-port synchronous RAM (ramlpm-style: address/data/we sampled on the rising edge, q registered one edge later). Shares the RAM between a user port (switch/key-driven read or write), an autonomous display scanner that reads one word per scan tick for HEX readout, and a zero-fill clear engine. Sits between the board I/O glue and the RAM instance; the RAM itself stays outside.

## Interface
- ADDR_W, 5, RAM address width (depth 2^ADDR_W = 32)
- DATA_W, 8, RAM word width
- SCAN_DIV, 50000000, clk50M cycles per scan tick (1 Hz at 50 MHz)

- clk50M  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- clr_req  in  1  start zero-fill of all words (level sampled in IDLE)
- a_req  in  1  user request; held with a_we/a_addr/a_wdata until a_ack
- a_we  in  1  1 = write, 0 = read
- a_addr  in  ADDR_W  user address
- a_wdata  in  DATA_W  user write data
- a_ack  out  1  one-cycle completion pulse
- a_rdata  out  DATA_W  read result, valid from a_ack onward, held until next user read
- scan_en  in  1  enables scan tick generation
- scan_addr  out  ADDR_W  address of last scanned word
- scan_data  out  DATA_W  data of last scanned word
- scan_valid  out  1  one-cycle pulse when scan_addr/scan_data update
- busy  out  1  high while clear in progress
- ram_addr  out  ADDR_W  to RAM address, registered
- ram_wdata  out  DATA_W  to RAM data, registered
- ram_we  out  1  to RAM write enable, registered
- ram_q  in  DATA_W  RAM registered read data

## Operation
- States: IDLE, CLEAR, ISSUE, CAPTURE.
- Reset values: all outputs 0; state IDLE; scan pointer 0; scan_pend 0; last-grant flag = scan (user wins first tie).
- Scan tick: divider counts 0..SCAN_DIV-1, tick on terminal count; divider held at 0 while scan_en=0. Tick sets scan_pend; tick while scan_pend already set is dropped.
- IDLE priority: clr_req > (a_req vs scan_pend round-robin). Both pending: grant the one not granted last. Single requester: grant it.
- Grant: register ram_addr/ram_wdata/ram_we (we=a_we for user, 0 for scan; scan address = internal pointer), go ISSUE -> CAPTURE -> IDLE. Leaving CAPTURE: latch ram_q into a_rdata (user read) or scan_data/scan_addr (scan), pulse a_ack or scan_valid; ram_we cleared on ISSUE exit. User write: a_rdata unchanged.
- Scan service clears scan_pend; pointer increments, 31 wraps to 0.
- CLEAR: busy=1, ram_we=1, ram_wdata=0, ram_addr steps 0..31 one per cycle; after address 31 return to IDLE, busy=0. clr_req during CLEAR ignored. Pending a_req waits; scan_pend retained; scan pointer unchanged.
- Reset mid-operation: immediate return to reset values; in-flight write may be lost; no ack issued.

## Timing
- User/scan access: request sampled in IDLE at edge E0; RAM samples address at E1; q captured at E2; a_ack/scan_valid high for cycle E2-E3. Latency 3 cycles, throughput one access per 3 cycles.
- a_req still high at E3 is treated as a new request.
- Clear: busy rises one edge after clr_req sampled, stays high exactly 32 cycles.
- Scan tick to scan_valid: 3 cycles minimum when uncontended; at most +3 if a user access is granted first.

## Structure
- Package ram_ctrl_pkg: state enum, ADDR_W/DATA_W defaults, RAM_DEPTH = 32.
- Sub-module scan_tick_gen: SCAN_DIV divider with enable, one-cycle tick output, width $clog2(SCAN_DIV).

## Test plan
(SCAN_DIV=8 in simulation, behavioural 32x8 RAM model attached.)
- Reset, then user write 0xA5 to addr 3, read addr 3 -> a_ack 3 cycles after each request, a_rdata=0xA5.
- scan_en=1 after writing 0x11..0x30 to addrs 0..31 -> scan_valid every 8 cycles, scan_addr 0,1,..,31,0 with matching data; wrap verified.
- a_req read held continuously with scan_en=1 -> grants alternate user/scan on ties, no scan tick starved beyond one user access.
- clr_req with a_req pending -> busy high 32 cycles, ram_we high 32 cycles, then user read of addr 17 returns 0x00.
- Two scan ticks while user/clear holds the RAM -> only one scan_valid, pointer advances by 1.
- reset asserted during ISSUE of a write -> all outputs 0 asynchronously, no a_ack, next access after release proceeds normally.
